// File: rtl/ccr_pkg.sv
// Shared condition-code definitions for the LC-3b datapath flag logic.
package ccr_pkg;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_RESET = 3'b010;

    function automatic logic br_eval(input nzp_t mask, input nzp_t flags);
        return |(mask & flags);
    endfunction

endpackage

// File: rtl/nzp_classify.sv
// Combinational result classifier: sign / zero / positive as a one-hot nzp_t.
module nzp_classify
    import ccr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] result,
    output nzp_t             nzp
);

    logic neg, zero;

    assign neg  = result[WIDTH-1];
    assign zero = (result == '0);

    always_comb begin
        nzp       = '0;
        nzp[CC_N] = neg;
        nzp[CC_Z] = zero;
        nzp[CC_P] = ~neg & ~zero;
    end

endmodule

// File: rtl/ccr_stack.sv
// N/Z/P condition-code register with a LIFO save stack for trap/interrupt entry
// and RTI, plus branch-condition evaluation. State updates on the falling edge.
module ccr_stack
    import ccr_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] result,
    input  logic             write,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [2:0]       br_nzp,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             br_taken,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    nzp_t             flags, flags_nxt, cls, top;
    nzp_t             stack [DEPTH];
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_rq, push_rq, pop_rq, clr_rq;
    logic             do_push, do_pop, misuse, err_nxt;

    nzp_classify #(.WIDTH(WIDTH)) u_cls (
        .result (result),
        .nzp    (cls)
    );

    assign wr_rq   = ~write;
    assign push_rq = ~push;
    assign pop_rq  = ~pop;
    assign clr_rq  = ~clr_err;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Push slot is the current count; pop reads the entry just below it.
    assign wr_idx = IDX_W'(count);
    assign rd_idx = IDX_W'(count - 1'b1);
    assign top    = stack[rd_idx];

    always_comb begin
        do_push   = push_rq & ~pop_rq & ~full;
        do_pop    = pop_rq & ~push_rq & ~empty;
        misuse    = (push_rq & pop_rq) | (push_rq & ~pop_rq & full) | (pop_rq & ~push_rq & empty);

        flags_nxt = flags;
        if (do_pop)
            flags_nxt = top;
        else if (wr_rq)
            flags_nxt = cls;

        cnt_nxt = count;
        if (do_push)
            cnt_nxt = count + 1'b1;
        else if (do_pop)
            cnt_nxt = count - 1'b1;

        // A fresh misuse on the same edge as a clear leaves err set.
        err_nxt = err;
        if (misuse)
            err_nxt = 1'b1;
        else if (clr_rq)
            err_nxt = 1'b0;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            flags <= NZP_RESET;
            count <= '0;
            err   <= 1'b0;
        end else begin
            flags <= flags_nxt;
            count <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(negedge clk) begin
        if (do_push)
            stack[wr_idx] <= flags;
    end

    assign n        = flags[CC_N];
    assign z        = flags[CC_Z];
    assign p        = flags[CC_P];
    assign br_taken = br_eval(br_nzp, flags);

endmodule

// File: tb/tb_ccr_stack.sv
// Directed plus randomized checks of ccr_stack against a queue-based flag model.
module tb_ccr_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b1;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic             write = 1'b1, push = 1'b1, pop = 1'b1, clr_err = 1'b1;
    logic [2:0]       br_nzp = 3'b000;
    logic             n, z, p, br_taken, full, empty, err;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_flags;
    bit         m_err;
    logic [2:0] m_q[$];

    ccr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .result   (result),
        .write    (write),
        .push     (push),
        .pop      (pop),
        .clr_err  (clr_err),
        .br_nzp   (br_nzp),
        .n        (n),
        .z        (z),
        .p        (p),
        .br_taken (br_taken),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == '0)        return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        br_nzp = 3'($urandom_range(0, 7));
        #1;
        chk({tag, ".nzp"},   {29'b0, n, z, p},  {29'b0, m_flags});
        chk({tag, ".br"},    {31'b0, br_taken}, {31'b0, |(br_nzp & m_flags)});
        chk({tag, ".count"}, {29'b0, count},    m_q.size());
        chk({tag, ".full"},  {31'b0, full},     {31'b0, m_q.size() == DEPTH});
        chk({tag, ".empty"}, {31'b0, empty},    {31'b0, m_q.size() == 0});
        chk({tag, ".err"},   {31'b0, err},      {31'b0, m_err});
    endtask

    // Called at a rising edge; inputs settle before the falling edge that samples them.
    task automatic op(input bit w, input bit pu, input bit po, input bit ce,
                      input logic [WIDTH-1:0] r, input string tag);
        bit         misuse = 1'b0;
        bit         popped = 1'b0;
        logic [2:0] old = m_flags;
        write = ~w; push = ~pu; pop = ~po; clr_err = ~ce; result = r;

        if (pu && po)
            misuse = 1'b1;
        else if (pu) begin
            if (m_q.size() == DEPTH) misuse = 1'b1;
            else                     m_q.push_back(old);
        end else if (po) begin
            if (m_q.size() == 0) misuse = 1'b1;
            else begin
                m_flags = m_q.pop_back();
                popped  = 1'b1;
            end
        end
        if (!popped && w) m_flags = classify(r);
        if (misuse)      m_err = 1'b1;
        else if (ce)     m_err = 1'b0;

        @(negedge clk);
        @(posedge clk);
        write = 1'b1; push = 1'b1; pop = 1'b1; clr_err = 1'b1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] vals [5];
        logic [WIDTH-1:0] r;
        int               sel;
        vals[0] = 16'h8000; vals[1] = 16'h0000; vals[2] = 16'h0007;
        vals[3] = 16'hFFFF; vals[4] = 16'h1234;

        m_flags = 3'b010;
        m_err   = 1'b0;
        repeat (2) @(posedge clk);
        check_all("reset");
        reset = 1'b1;
        @(posedge clk);

        op(1, 0, 0, 0, 16'h8000, "w_neg");
        op(1, 0, 0, 0, 16'h0000, "w_zero");
        op(1, 0, 0, 0, 16'h0005, "w_pos");
        op(1, 1, 0, 0, 16'hFFFF, "push_w");
        op(0, 0, 1, 0, 16'h0000, "pop");

        for (int i = 0; i < 5; i++) op(1, 1, 0, 0, vals[i], "push_fill");
        for (int i = 0; i < 4; i++) op(0, 0, 1, 0, 16'h0000, "pop_rev");
        op(1, 0, 1, 0, 16'h0003, "pop_empty");
        op(0, 0, 0, 1, 16'h0000, "clr");

        op(1, 1, 0, 0, 16'h0000, "push_a");
        op(1, 1, 0, 0, 16'h8001, "push_b");
        op(0, 1, 1, 0, 16'h0000, "push_pop");
        op(1, 0, 1, 0, 16'h0000, "pop_w");
        op(0, 0, 1, 0, 16'h0000, "pop_last");
        op(0, 0, 1, 1, 16'h0000, "clr_vs_misuse");
        op(0, 0, 0, 1, 16'h0000, "clr2");

        for (int i = 0; i < 3; i++) op(1, 1, 0, 0, vals[i + 2], "push_pre_rst");
        op(0, 1, 1, 0, 16'h0000, "misuse_pre_rst");
        #2;
        reset   = 1'b0;
        m_q.delete();
        m_flags = 3'b010;
        m_err   = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        reset = 1'b1;
        op(1, 1, 0, 0, 16'h0005, "push_post_rst");
        op(0, 0, 1, 0, 16'h0000, "pop_post_rst");

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            r   = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : WIDTH'($urandom);
            op(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
               ($urandom_range(0, 9) < 4), ($urandom_range(0, 4) == 0), r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccr_stack.md
# ccr_stack

Parametrised condition-code unit for the LC-3b datapath. It classifies each WIDTH-bit destination result into one-hot N/Z/P flags, holds them in a register, and evaluates BR conditions. It also adds a DEPTH-entry save/restore stack, so interrupt or trap entry can push the flags and RTI can pop them. It replaces the three separate single-bit N/Z/P registers and sits beside the register file, updating on the same clock edge.

## Interface
- WIDTH, 16, bit width of the result being classified
- DEPTH, 4, number of save-stack entries (≥1)
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, do not override)

- clk  input  1  clock; all state updates on the falling edge
- reset  input  1  asynchronous, active-low reset
- result  input  WIDTH  value being written to the destination register
- write  input  1  active-low; load flags from `result`
- push  input  1  active-low; save current flags onto stack
- pop  input  1  active-low; restore flags from top of stack
- clr_err  input  1  active-low; clear sticky `err`
- br_nzp  input  3  instruction bits [11:9] as {n,z,p} mask
- n, z, p  output  1 each  registered condition codes
- br_taken  output  1  combinational: |(br_nzp & {n,z,p})
- count  output  CNT_W  stack occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- err  output  1  sticky stack-misuse flag

## Operation
- Classification: n = result[WIDTH-1]; z = (result == 0); p = ~n & ~z. The result is exactly one-hot.
- Flags invariant: {n,z,p} is always one-hot, including after reset and pop.
- Write (write=0, pop=1): flags load the classification of `result`.
- Push (push=0, pop=1, not full): stack[count] ← current {n,z,p} (the value before this edge), and count increments. A write on the same edge still updates the flags, so the saved value is the old one.
- Pop (pop=0, push=1, not empty): flags ← stack[count-1], and count decrements. A pop overrides a simultaneous write, so the write is discarded.
- Push when full: the stack and count are unchanged and err is set. A concurrent write still applies.
- Pop when empty: the flags and count are unchanged, a concurrent write still applies, and err is set.
- Push and pop on the same edge: the stack and count are unchanged, err is set, and a concurrent write applies.
- Error clearing: clr_err=0 clears err. If a new misuse happens on the same edge, set wins and err=1.
- br_taken is purely combinational from the registered flags. It carries no state.

## Timing
- Reset (reset=0, asynchronous) forces {n,z,p}=3'b010, count=0, empty=1, full=0, err=0. Stack contents are don't-care.
- Reset asserted mid-operation overrides all other inputs immediately. Release takes effect at the next falling edge.
- Latency: flag, count and err changes become visible after the falling edge on which the control input is sampled low.
- br_taken follows the new flags in that same cycle.
- full and empty are decoded from registered `count`, with no extra cycle.
- Back-to-back operations are legal on every edge. Alternating push and pop gives full throughput.
- The stack is a LIFO with no wrap-around. Occupancy saturates at 0 and DEPTH, with err reporting each saturation attempt.

## Structure
- Shared package `ccr_pkg` holds:
  - bit-index constants CC_N=2, CC_Z=1, CC_P=0;
  - typedef `nzp_t` (3-bit);
  - constant `NZP_RESET` = 3'b010.
- One sub-module, `nzp_classify` (combinational, WIDTH-parametrised: result → nzp_t). It is reused by the ALU-flag path.
- The stack array, pointer/count and err logic are implemented in `ccr_stack` itself.

## Test plan
- Reset, then write with result=16'h8000, then 16'h0000, then 16'h0005 → flags go 100, 010, 001. br_nzp=3'b011 gives br_taken 0, 1, 1.
- From flags=001, push with simultaneous write result=16'hFFFF → stack[0]=001, flags=100, count=1. Then pop → flags=001, count=0.
- DEPTH=4: five pushes → count=4, full=1, err=1 set on the 5th push, earlier entries intact. Four pops restore the entries in reverse order, ending with empty=1.
- Pop with count=0 and write result=16'h0003 → flags=001, count stays 0, err=1. Then clr_err=0 → err=0.
- count=2: push and pop on the same edge → count stays 2, flags unchanged, err=1. Pop with write result=0 → flags come from the stack and the write is ignored.
- Assert reset between edges at count=3, err=1 → immediately flags=010, count=0, err=0. First push after release stores 010.
